// File: rtl/rand_target_sequencer_if.sv
// Target handshake bundle between the sequencer and the game/draw logic.
// The sequencer side is master; the consumer side is slave.
interface rand_target_sequencer_if;
  logic [5:0] target;
  logic       target_valid;
  logic       target_ready;
  logic [3:0] count;
  logic       busy;
  logic       done;

  modport master (
    output target, target_valid, count, busy, done,
    input  target_ready
  );

  modport slave (
    input  target, target_valid, count, busy, done,
    output target_ready
  );
endinterface

// File: rtl/rand_target_sequencer.sv
// Seeds a 6-bit LFSR from the selected difficulty counter on start and issues
// SEQ_LEN masked, non-repeating target indices over a valid/ready handshake.
module rand_target_sequencer #(
  parameter int SEQ_LEN = 8
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    start,
  input  logic [1:0]              difficulty,
  input  logic [3:0]              myStateEasy,
  input  logic [4:0]              myStateMedium,
  input  logic [5:0]              myStateHard,
  output logic                    hold_rand,
  rand_target_sequencer_if.master tgt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_GEN,
    S_OUT,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_diff;
  logic [5:0] r_seed;
  logic [5:0] r_lfsr;
  logic [5:0] r_target;
  logic [3:0] r_count;
  logic       r_first;

  logic [5:0] w_lfsr_next;
  logic [5:0] w_mask;
  logic [5:0] w_cand;
  logic [5:0] w_seed_raw;
  logic [5:0] w_seed_sel;
  logic       w_repeat;
  logic       w_last;

  assign w_lfsr_next = {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4]};
  assign w_cand      = w_lfsr_next & w_mask;
  assign w_repeat    = !r_first && (w_cand == r_target);
  assign w_last      = (r_count == 4'(SEQ_LEN - 1));

  always_comb begin
    w_mask = 6'h3F;
    case (r_diff)
      2'd0:    w_mask = 6'h0F;
      2'd1:    w_mask = 6'h1F;
      default: w_mask = 6'h3F;
    endcase
  end

  // An all-zero seed would lock the LFSR at zero, so it is nudged to 1.
  always_comb begin
    w_seed_raw = myStateHard;
    case (difficulty)
      2'd0:    w_seed_raw = {2'b00, myStateEasy};
      2'd1:    w_seed_raw = {1'b0, myStateMedium};
      default: w_seed_raw = myStateHard;
    endcase
    w_seed_sel = (w_seed_raw == 6'd0) ? 6'h01 : w_seed_raw;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SEED;
      S_SEED:  w_state_nxt = S_GEN;
      S_GEN:   if (!w_repeat) w_state_nxt = S_OUT;
      S_OUT:   if (tgt.target_ready) w_state_nxt = w_last ? S_DONE : S_GEN;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_diff   <= 2'd0;
      r_seed   <= 6'd0;
      r_lfsr   <= 6'd0;
      r_target <= 6'd0;
      r_count  <= 4'd0;
      r_first  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_diff <= difficulty;
            r_seed <= w_seed_sel;
          end
        end
        S_SEED: begin
          r_lfsr  <= r_seed;
          r_count <= 4'd0;
          r_first <= 1'b1;
        end
        S_GEN: begin
          r_lfsr <= w_lfsr_next;
          if (!w_repeat) begin
            r_target <= w_cand;
            r_first  <= 1'b0;
          end
        end
        S_OUT: begin
          if (tgt.target_ready) r_count <= r_count + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign tgt.target       = r_target;
  assign tgt.target_valid = (r_state == S_OUT);
  assign tgt.count        = r_count;
  assign tgt.busy         = (r_state != S_IDLE);
  assign tgt.done         = (r_state == S_DONE);
  assign hold_rand        = (r_state != S_IDLE);

endmodule

// File: tb/tb_rand_target_sequencer.sv
// Scoreboard bench for rand_target_sequencer: an LFSR model queues the expected
// targets at start and each accepted handshake pops and compares one.
module tb_rand_target_sequencer;
  localparam int SEQ_LEN = 8;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       start = 1'b0;
  logic [1:0] difficulty = 2'd0;
  logic [3:0] myStateEasy = 4'd0;
  logic [4:0] myStateMedium = 5'd0;
  logic [5:0] myStateHard = 6'd0;
  logic       hold_rand;

  rand_target_sequencer_if bus();

  rand_target_sequencer #(.SEQ_LEN(SEQ_LEN)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .start         (start),
    .difficulty    (difficulty),
    .myStateEasy   (myStateEasy),
    .myStateMedium (myStateMedium),
    .myStateHard   (myStateHard),
    .hold_rand     (hold_rand),
    .tgt           (bus)
  );

  always #5 Clk = ~Clk;

  int         errors = 0;
  int         checks = 0;
  logic [5:0] exp_q[$];
  logic [5:0] obs[$];
  logic [5:0] hard_obs[$];
  logic [5:0] easy_ref [8] = '{6'd2, 6'd4, 6'd8, 6'd0, 6'd1, 6'd3, 6'd6, 6'd12};
  logic [5:0] hard_ref [8] = '{6'd2, 6'd4, 6'd8, 6'd16, 6'd33, 6'd3, 6'd6, 6'd12};

  function automatic logic [5:0] mask_of(input logic [1:0] d);
    if (d == 2'd0) return 6'h0F;
    if (d == 2'd1) return 6'h1F;
    return 6'h3F;
  endfunction

  function automatic logic [5:0] step(input logic [5:0] v);
    return {v[4:0], v[5] ^ v[4]};
  endfunction

  task automatic push_expected(input logic [1:0] d, input logic [5:0] raw);
    logic [5:0] l, c, prev;
    bit first;
    l = (raw == 6'd0) ? 6'd1 : raw;
    first = 1'b1;
    prev = 6'd0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      do begin
        l = step(l);
        c = l & mask_of(d);
      end while (!first && c == prev);
      exp_q.push_back(c);
      prev = c;
      first = 1'b0;
    end
  endtask

  task automatic play_round(input logic [1:0] d, input logic [3:0] e, input logic [4:0] m,
                            input logic [5:0] h, input int ready_pct, input bit disturb);
    logic [5:0] raw, prev, got, ex;
    int acc;
    bit seen_done, have_prev;
    obs.delete();
    exp_q.delete();
    @(negedge Clk);
    difficulty = d; myStateEasy = e; myStateMedium = m; myStateHard = h;
    start = 1'b1;
    raw = (d == 2'd0) ? {2'b00, e} : (d == 2'd1) ? {1'b0, m} : h;
    push_expected(d, raw);
    @(negedge Clk);
    start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || hold_rand !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise: busy=%b hold_rand=%b required 1/1", bus.busy, hold_rand);
    end
    acc = 0; seen_done = 1'b0; have_prev = 1'b0; prev = 6'd0;
    for (int cyc = 0; cyc < 2000 && !seen_done; cyc++) begin
      if (cyc > 0) @(negedge Clk);
      if (bus.done === 1'b1) begin
        seen_done = 1'b1;
        start = 1'b0;
        bus.target_ready = 1'b0;
      end else begin
        checks++;
        if (hold_rand !== 1'b1) begin
          errors++;
          $display("FAIL hold_rand_round: got %b required 1", hold_rand);
        end
        if (disturb) begin
          myStateEasy = 4'($urandom); myStateMedium = 5'($urandom); myStateHard = 6'($urandom);
          start = 1'($urandom_range(1));
        end
        bus.target_ready = ($urandom_range(99) < ready_pct);
        if (bus.target_valid === 1'b1) begin
          checks++;
          if (bus.count !== 4'(acc)) begin
            errors++;
            $display("FAIL count_track: got %0d required %0d", bus.count, acc);
          end
          if (bus.target_ready) begin
            got = bus.target;
            obs.push_back(got);
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL extra_target: got %0d with no expected entry", got);
            end else begin
              ex = exp_q.pop_front();
              if (got !== ex) begin
                errors++;
                $display("FAIL target_seq[%0d]: got %0d required %0d", acc, got, ex);
              end
            end
            checks++;
            if ((got & ~mask_of(d)) != 6'd0) begin
              errors++;
              $display("FAIL target_range: got %0d mask %0h", got, mask_of(d));
            end
            if (have_prev) begin
              checks++;
              if (got == prev) begin
                errors++;
                $display("FAIL repeat: got %0d twice in a row", got);
              end
            end
            prev = got; have_prev = 1'b1;
            acc++;
          end
        end
      end
    end
    start = 1'b0;
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL done_timeout: no done seen, accepted %0d", acc);
    end
    checks++;
    if (acc != SEQ_LEN || exp_q.size() != 0 || bus.count !== 4'(SEQ_LEN)) begin
      errors++;
      $display("FAIL round_total: accepted %0d count %0d left %0d required %0d", acc, bus.count,
               exp_q.size(), SEQ_LEN);
    end
    @(negedge Clk);
    checks++;
    if (bus.busy !== 1'b0 || hold_rand !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL after_done: busy=%b hold=%b done=%b required 0/0/0", bus.busy, hold_rand, bus.done);
    end
  endtask

  task automatic check_against_ref(input string name, input logic [5:0] r [8]);
    checks++;
    if (obs.size() != SEQ_LEN) begin
      errors++;
      $display("FAIL %s_len: got %0d required %0d", name, obs.size(), SEQ_LEN);
    end else begin
      for (int i = 0; i < SEQ_LEN; i++) begin
        checks++;
        if (obs[i] !== r[i]) begin
          errors++;
          $display("FAIL %s[%0d]: got %0d required %0d", name, i, obs[i], r[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.target, bus.target_valid, bus.count, bus.busy, bus.done, hold_rand} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: target=%0d valid=%b count=%0d busy=%b done=%b hold=%b required all 0",
               bus.target, bus.target_valid, bus.count, bus.busy, bus.done, hold_rand);
    end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.count !== 4'd0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b count=%0d required 0/0", bus.busy, bus.count);
    end
  endtask

  task automatic test_easy();
    play_round(2'd0, 4'd0, 5'd0, 6'd0, 100, 1'b0);
    check_against_ref("easy", easy_ref);
  endtask

  task automatic test_hard();
    play_round(2'd2, 4'd0, 5'd0, 6'h01, 100, 1'b0);
    check_against_ref("hard", hard_ref);
    hard_obs = obs;
    play_round(2'd3, 4'd0, 5'd0, 6'h01, 100, 1'b0);
    for (int i = 0; i < SEQ_LEN; i++) begin
      checks++;
      if (obs.size() != SEQ_LEN || obs[i] !== hard_obs[i]) begin
        errors++;
        $display("FAIL diff3_same[%0d]: diff3 differs from diff2 sequence", i);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] t0;
    logic [3:0] c0;
    int n;
    exp_q.delete();
    push_expected(2'd0, 6'd5);
    bus.target_ready = 1'b0;
    @(negedge Clk);
    difficulty = 2'd0; myStateEasy = 4'd5; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    n = 0;
    while (bus.target_valid !== 1'b1 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    t0 = bus.target; c0 = bus.count;
    checks++;
    if (bus.target_valid !== 1'b1 || t0 !== exp_q[0]) begin
      errors++;
      $display("FAIL bp_first: valid=%b target=%0d required 1/%0d", bus.target_valid, t0, exp_q[0]);
    end
    repeat (5) begin
      @(negedge Clk);
      checks++;
      if (bus.target !== t0 || bus.target_valid !== 1'b1 || bus.count !== c0) begin
        errors++;
        $display("FAIL bp_stable: target=%0d valid=%b count=%0d required %0d/1/%0d",
                 bus.target, bus.target_valid, bus.count, t0, c0);
      end
    end
    bus.target_ready = 1'b1;
    @(negedge Clk);
    bus.target_ready = 1'b0;
    checks++;
    if (bus.count !== c0 + 4'd1) begin
      errors++;
      $display("FAIL bp_advance: count=%0d required %0d", bus.count, c0 + 4'd1);
    end
    bus.target_ready = 1'b1;
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    bus.target_ready = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.count !== 4'(SEQ_LEN)) begin
      errors++;
      $display("FAIL bp_finish: done=%b count=%0d required 1/%0d", bus.done, bus.count, SEQ_LEN);
    end
    @(negedge Clk);
  endtask

  task automatic test_freeze();
    play_round(2'd0, 4'd0, 5'd0, 6'd0, 70, 1'b1);
    check_against_ref("freeze", easy_ref);
  endtask

  task automatic test_async_reset();
    int n;
    @(negedge Clk);
    difficulty = 2'd0; myStateEasy = 4'd0; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    n = 0;
    while (!(bus.target_valid === 1'b1 && bus.count === 4'd3) && n < 100) begin
      bus.target_ready = 1'b1;
      @(negedge Clk);
      n++;
    end
    bus.target_ready = 1'b0;
    checks++;
    if (bus.target_valid !== 1'b1 || bus.count !== 4'd3) begin
      errors++;
      $display("FAIL ar_setup: valid=%b count=%0d required 1/3", bus.target_valid, bus.count);
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.target, bus.target_valid, bus.count, bus.busy, bus.done, hold_rand} !== 14'd0) begin
      errors++;
      $display("FAIL ar_outputs: target=%0d valid=%b count=%0d busy=%b done=%b hold=%b required all 0",
               bus.target, bus.target_valid, bus.count, bus.busy, bus.done, hold_rand);
    end
    repeat (3) begin
      @(negedge Clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL ar_hold: done=%b busy=%b required 0/0", bus.done, bus.busy);
      end
    end
    Reset_n = 1'b1;
    play_round(2'd0, 4'd0, 5'd0, 6'd0, 100, 1'b0);
    check_against_ref("ar_restart", easy_ref);
  endtask

  task automatic test_random_sweep();
    for (int r = 0; r < 16; r++) begin
      play_round(2'(r % 4), 4'($urandom), 5'($urandom), 6'($urandom), 50, 1'($urandom_range(1)));
    end
  endtask

  initial begin
    bus.target_ready = 1'b0;
    test_reset();
    test_easy();
    test_hard();
    test_backpressure();
    test_freeze();
    test_async_reset();
    test_random_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rand_target_sequencer.md
# rand_target_sequencer

Downstream consumer of the free-running difficulty counters (`myStateEasy` / `myStateMedium` / `myStateHard`). On a `start` pulse it:
- captures the counter value for the selected difficulty as a seed;
- freezes the counters while it works;
- expands the seed through a 6-bit LFSR into `SEQ_LEN` target indices, masked to that difficulty's range.

Targets go to the game/draw logic over a valid/ready handshake. No target equals the one issued immediately before it.

## Interface
- `SEQ_LEN`, default 8: targets issued per round; legal range 1..15.
- `Clk`  in  1: system clock, rising edge.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a round; sampled only in IDLE.
- `difficulty`  in  2: 0 easy, 1 medium, 2 hard, 3 treated as hard; sampled with `start`.
- `myStateEasy`  in  4: easy counter value.
- `myStateMedium`  in  5: medium counter value.
- `myStateHard`  in  6: hard counter value.
- `hold_rand`  out  1: drives the counter block's `enable`; 1 freezes the counters.
- `target`  out  6: current target index, upper bits zero per mask.
- `target_valid`  out  1: `target` is valid.
- `target_ready`  in  1: consumer accepts `target`.
- `count`  out  4: targets accepted so far this round.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse after the last target is accepted.

## Operation
- **States:** IDLE, SEED, GEN, OUT, DONE.
- **IDLE**
  - On `start`=1: latch `difficulty` into `diff_r`, go to SEED.
  - In the same edge, latch `seed` = selected counter value zero-extended to 6 bits.
  - `seed`=0 is replaced by 6'h01.
- **SEED** (1 cycle): `lfsr` <= `seed`, `count` <= 0, `first` <= 1. Go to GEN.
- **GEN**, each cycle:
  - `lfsr` <= `lfsr_next` = {lfsr[4:0], lfsr[5]^lfsr[4]}.
  - `cand` = `lfsr_next` & `mask`.
  - `mask`: easy 6'h0F, medium 6'h1F, hard 6'h3F.
  - If `first`=0 and `cand`==`target`: stay in GEN (re-step).
  - Otherwise: `target` <= `cand`, `first` <= 0, go to OUT.
- **OUT**
  - `target_valid`=1; `target` is held stable until accepted.
  - On `target_ready`=1: `count` <= `count`+1.
  - If `count`==`SEQ_LEN`-1: go to DONE; else go to GEN.
- **DONE** (1 cycle): `done`=1, go to IDLE. `target` keeps its last value.
- `hold_rand` = `busy`. In IDLE the counters run free.
- `start` is ignored outside IDLE; a new round needs IDLE plus a fresh `start`.
- Counter inputs are sampled only on the IDLE->SEED edge. Changes afterwards have no effect.
- Reset (any state, asynchronous):
  - state -> IDLE;
  - `lfsr`, `seed`, `target`, `count`, `diff_r` -> 0; `first` -> 1;
  - all outputs 0 while `Reset_n`=0;
  - a round in progress is abandoned and no `done` is produced.

## Timing
- All outputs are registered or decoded from the state register. There is no combinational path from `target_ready` or `start` to any output.
- Latency for the first target: `start` at edge N -> SEED at N+1 -> `target_valid` high after edge N+2, assuming no re-step.
- Subsequent targets: handshake at edge M -> GEN -> `target_valid` high after edge M+1. Each re-step adds one cycle.
- Maximum throughput: one target per 2 cycles.
- `done` is high for exactly one cycle, immediately after the edge that accepts target number `SEQ_LEN`.
- `busy` and `hold_rand` rise the cycle after `start` is sampled and fall the cycle after DONE.

## Test plan
- **Easy round:** reset, `difficulty`=0, `myStateEasy`=0 (seed forced to 1), `target_ready`=1, pulse `start`.
  - Targets are 2, 4, 8, 0, 1, 3, 6, 12.
  - `count` ends at 8; `done` pulses once; `busy` is low two cycles later.
- **Hard round:** `difficulty`=2, `myStateHard`=6'h01.
  - First targets are 2, 4, 8, 16, 33, 3, 6, 12, all ≤ 63.
  - `difficulty`=3 with the same seed gives the identical sequence.
- **Backpressure:** hold `target_ready`=0 for 5 cycles in OUT.
  - `target` and `target_valid` stay stable; `count` does not change.
  - The following single-cycle `target_ready` advances `count` by exactly 1.
- **Freeze / ignore:**
  - `hold_rand`=1 throughout the round.
  - Changing `myState*` and pulsing `start` mid-round does not alter the sequence or restart the round.
- **Async reset mid-round:** drop `Reset_n` in OUT with `count`=3.
  - All outputs read 0 before the next edge; state is IDLE; no `done`.
  - After release, a new `start` reproduces the sequence from the beginning.
- **Random sweep:** all difficulties and seeds, random `target_ready`.
  - Check no consecutive repeat, `target` ≤ mask, exactly `SEQ_LEN` accepts per `done`.
  - Check a scoreboard LFSR model matches.
